// File: rtl/dual_issue_scheduler_if.sv
// rtl/dual_issue_scheduler_if.sv - decode-to-issue pair bus for the dual-issue scheduler
interface dual_issue_scheduler_if #(
  parameter int ADDR_W = 7,
  parameter int CNT_W  = 3
);
  logic                  pair_valid;
  logic                  i0_pipe;
  logic                  i1_pipe;
  logic [3*ADDR_W-1:0]   i0_src;
  logic [3*ADDR_W-1:0]   i1_src;
  logic [2:0]            i0_src_use;
  logic [2:0]            i1_src_use;
  logic [ADDR_W-1:0]     i0_rt;
  logic [ADDR_W-1:0]     i1_rt;
  logic                  i0_wr;
  logic                  i1_wr;
  logic [CNT_W-1:0]      i0_lat;
  logic [CNT_W-1:0]      i1_lat;
  logic                  issue_even;
  logic                  issue_odd;
  logic                  issue_even_slot;
  logic                  issue_odd_slot;
  logic                  stall;
  logic                  second_pending;
  logic [15:0]           issue_count;

  modport master (
    output pair_valid, i0_pipe, i1_pipe, i0_src, i1_src, i0_src_use, i1_src_use,
           i0_rt, i1_rt, i0_wr, i1_wr, i0_lat, i1_lat,
    input  issue_even, issue_odd, issue_even_slot, issue_odd_slot, stall,
           second_pending, issue_count
  );

  modport slave (
    input  pair_valid, i0_pipe, i1_pipe, i0_src, i1_src, i0_src_use, i1_src_use,
           i0_rt, i1_rt, i0_wr, i1_wr, i0_lat, i1_lat,
    output issue_even, issue_odd, issue_even_slot, issue_odd_slot, stall,
           second_pending, issue_count
  );
endinterface

// File: rtl/dual_issue_scheduler.sv
// rtl/dual_issue_scheduler.sv - in-order dual-issue controller with per-register latency scoreboard
module dual_issue_scheduler #(
  parameter int NUM_REGS = 128,
  parameter int ADDR_W   = 7,
  parameter int CNT_W    = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  dual_issue_scheduler_if.slave bus
);

  typedef enum logic {PAIR = 1'b0, SECOND = 1'b1} state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t                         state, state_next;
  logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
  logic [15:0]                    count_q;

  logic [CNT_W-1:0] lat0, lat1;
  logic             raw0, raw1, waw0, waw1, haz0, haz1;
  logic             i1_reads_i0, i1_pair_ok;
  logic             iss0, iss1;
  logic             ie, io, ies, ios, st;

  // A zero latency is treated as single-cycle.
  assign lat0 = (bus.i0_lat == '0) ? ONE : bus.i0_lat;
  assign lat1 = (bus.i1_lat == '0) ? ONE : bus.i1_lat;

  // Scoreboard lookups: pending sources (RAW) and i1's dependence on i0 within the pair.
  always_comb begin
    raw0        = 1'b0;
    raw1        = 1'b0;
    i1_reads_i0 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (bus.i0_src_use[k] && (cnt[bus.i0_src[k*ADDR_W +: ADDR_W]] != '0)) raw0 = 1'b1;
      if (bus.i1_src_use[k] && (cnt[bus.i1_src[k*ADDR_W +: ADDR_W]] != '0)) raw1 = 1'b1;
      if (bus.i1_src_use[k] && (bus.i1_src[k*ADDR_W +: ADDR_W] == bus.i0_rt)) i1_reads_i0 = 1'b1;
    end
  end

  // An older write still outstanding at or beyond our own latency would land after ours.
  assign waw0 = bus.i0_wr && (cnt[bus.i0_rt] >= lat0);
  assign waw1 = bus.i1_wr && (cnt[bus.i1_rt] >= lat1);
  assign haz0 = raw0 || waw0;
  assign haz1 = raw1 || waw1;

  assign i1_pair_ok = (bus.i1_pipe != bus.i0_pipe) && !haz1 &&
                      !(bus.i0_wr && i1_reads_i0) &&
                      !(bus.i0_wr && bus.i1_wr && (bus.i1_rt == bus.i0_rt));

  // Issue decision, stall and next state; reset silences every output at once.
  always_comb begin
    state_next = state;
    iss0       = 1'b0;
    iss1       = 1'b0;
    st         = 1'b0;
    if (reset || flush) begin
      state_next = PAIR;
    end else begin
      case (state)
        PAIR: begin
          if (bus.pair_valid) begin
            if (haz0) begin
              st = 1'b1;
            end else begin
              iss0 = 1'b1;
              if (i1_pair_ok) begin
                iss1 = 1'b1;
              end else begin
                st         = 1'b1;
                state_next = SECOND;
              end
            end
          end
        end
        SECOND: begin
          if (!haz1) begin
            iss1       = 1'b1;
            state_next = PAIR;
          end else begin
            st = 1'b1;
          end
        end
        default: state_next = PAIR;
      endcase
    end
  end

  // Route issued instructions to their pipes and record which slot each pipe took.
  always_comb begin
    ie  = 1'b0;
    io  = 1'b0;
    ies = 1'b0;
    ios = 1'b0;
    if (iss0) begin
      if (bus.i0_pipe) io = 1'b1;
      else             ie = 1'b1;
    end
    if (iss1) begin
      if (bus.i1_pipe) begin
        io  = 1'b1;
        ios = 1'b1;
      end else begin
        ie  = 1'b1;
        ies = 1'b1;
      end
    end
  end

  assign bus.issue_even      = ie;
  assign bus.issue_odd       = io;
  assign bus.issue_even_slot = ies;
  assign bus.issue_odd_slot  = ios;
  assign bus.stall           = st;
  assign bus.second_pending  = (state == SECOND) && !reset;
  assign bus.issue_count     = count_q;

  // Pair/second state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= PAIR;
    else       state <= state_next;
  end

  // Scoreboard: a new write load takes priority over the per-cycle countdown.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (iss0 && bus.i0_wr && (bus.i0_rt == ADDR_W'(r)))      cnt[r] <= lat0 - ONE;
        else if (iss1 && bus.i1_wr && (bus.i1_rt == ADDR_W'(r))) cnt[r] <= lat1 - ONE;
        else if (cnt[r] != '0)                                   cnt[r] <= cnt[r] - ONE;
      end
    end
  end

  // Running total of dispatched instructions, wrapping at 16 bits.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_q + {15'd0, ie} + {15'd0, io};
  end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// tb/tb_dual_issue_scheduler.sv - self-checking bench for dual_issue_scheduler
module tb_dual_issue_scheduler;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;

  dual_issue_scheduler_if #(.ADDR_W(7), .CNT_W(3)) bus ();

  dual_issue_scheduler #(.NUM_REGS(128), .ADDR_W(7), .CNT_W(3)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        pipe;
    logic [20:0] src;
    logic [2:0]  use_m;
    logic [6:0]  rt;
    logic        wr;
    logic [2:0]  lat;
  } instr_t;

  typedef struct {
    string      name;
    logic       fl;
    logic       v;
    instr_t     a;
    instr_t     b;
    logic [5:0] exp;
  } vec_t;

  // output order: {issue_even, even_slot, issue_odd, odd_slot, stall, second_pending}
  localparam logic [5:0] DUAL    = 6'b10_11_00;
  localparam logic [5:0] E0_HOLD = 6'b10_00_10;
  localparam logic [5:0] STALLED = 6'b00_00_10;

  int checks = 0;
  int errors = 0;

  function automatic instr_t mk(logic pipe, logic [6:0] ra, logic [6:0] rb, logic [6:0] rc,
                                logic [2:0] use_m, logic [6:0] rt, logic wr, logic [2:0] lat);
    instr_t x;
    x.pipe  = pipe;
    x.src   = {rc, rb, ra};
    x.use_m = use_m;
    x.rt    = rt;
    x.wr    = wr;
    x.lat   = lat;
    return x;
  endfunction

  task automatic drive(logic v, instr_t a, instr_t b);
    bus.pair_valid = v;
    bus.i0_pipe = a.pipe;  bus.i0_src = a.src;  bus.i0_src_use = a.use_m;
    bus.i0_rt = a.rt;      bus.i0_wr = a.wr;    bus.i0_lat = a.lat;
    bus.i1_pipe = b.pipe;  bus.i1_src = b.src;  bus.i1_src_use = b.use_m;
    bus.i1_rt = b.rt;      bus.i1_wr = b.wr;    bus.i1_lat = b.lat;
  endtask

  function automatic logic [5:0] outs();
    return {bus.issue_even, bus.issue_even_slot, bus.issue_odd, bus.issue_odd_slot,
            bus.stall, bus.second_pending};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step_chk(string name, logic [5:0] exp);
    @(negedge clock);
    chk(name, 32'(outs()), 32'(exp));
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, mk(0, 0, 0, 0, 0, 0, 0, 1), mk(1, 0, 0, 0, 0, 0, 0, 1));
  endtask

  task automatic count_chk(string name, logic [15:0] exp);
    @(negedge clock);
    chk(name, 32'(bus.issue_count), 32'(exp));
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush = 1'b0;
    #2;
    chk("reset_outs", 32'(outs()), 32'd0);
    chk("reset_count", 32'(bus.issue_count), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Reference model: absolute cycle at which each register's value becomes available.
  int         ready [128];
  int         now;
  bit         pend;
  logic [15:0] mcount;

  function automatic int leff(logic [2:0] l);
    return (l == 3'd0) ? 1 : int'(l);
  endfunction

  function automatic bit m_haz(instr_t x);
    for (int k = 0; k < 3; k++)
      if (x.use_m[k] && ready[x.src[k*7 +: 7]] > now) return 1'b1;
    if (x.wr && (ready[x.rt] - now) >= leff(x.lat)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit reads(instr_t x, logic [6:0] r);
    for (int k = 0; k < 3; k++)
      if (x.use_m[k] && x.src[k*7 +: 7] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic instr_t rnd_instr();
    return mk(1'($urandom_range(1)), 7'($urandom_range(7)), 7'($urandom_range(7)),
              7'($urandom_range(7)), 3'($urandom_range(7)), 7'($urandom_range(7)),
              1'($urandom_range(1)), 3'($urandom_range(7)));
  endfunction

  vec_t tbl [10];

  initial begin
    instr_t ra_, rb_;
    logic   rv;
    bit     hold;

    tbl[0] = '{"indep_dual", 0, 1, mk(0,0,0,0,0,3,1,2), mk(1,0,0,0,0,4,1,4), DUAL};
    tbl[1] = '{"same_even", 0, 1, mk(0,0,0,0,0,3,1,2), mk(0,0,0,0,0,4,1,4), E0_HOLD};
    tbl[2] = '{"swapped_pipes", 0, 1, mk(1,0,0,0,0,3,1,2), mk(0,0,0,0,0,4,1,4), 6'b11_10_00};
    tbl[3] = '{"intra_raw", 0, 1, mk(0,0,0,0,0,5,1,2), mk(1,5,0,0,3'b001,6,1,1), E0_HOLD};
    tbl[4] = '{"intra_waw", 0, 1, mk(0,0,0,0,0,9,1,3), mk(1,0,0,0,0,9,1,3), E0_HOLD};
    tbl[5] = '{"i0_no_write", 0, 1, mk(0,0,0,0,0,9,0,3), mk(1,9,9,9,3'b111,2,1,1), DUAL};
    tbl[6] = '{"unused_src", 0, 1, mk(0,0,0,0,0,5,1,2), mk(1,5,5,5,3'b000,6,1,1), DUAL};
    tbl[7] = '{"no_pair", 0, 0, mk(0,0,0,0,0,3,1,2), mk(1,0,0,0,0,4,1,4), 6'b00_00_00};
    tbl[8] = '{"flush_pair", 1, 1, mk(0,0,0,0,0,3,1,2), mk(1,0,0,0,0,4,1,4), 6'b00_00_00};
    tbl[9] = '{"same_odd", 0, 1, mk(1,0,0,0,0,3,1,2), mk(1,0,0,0,0,4,1,4), 6'b00_10_10};

    idle();
    #1;

    foreach (tbl[i]) begin
      do_reset();
      flush = tbl[i].fl;
      drive(tbl[i].v, tbl[i].a, tbl[i].b);
      step_chk(tbl[i].name, tbl[i].exp);
      flush = 1'b0;
    end

    // Independent pair dual-issues; count reflects both next cycle.
    do_reset();
    drive(1, mk(0,0,0,0,0,3,1,2), mk(1,0,0,0,0,4,1,4));
    step_chk("tp1_issue", DUAL);
    idle();
    count_chk("tp1_count", 16'd2);

    // Same-pipe pair splits across two cycles.
    do_reset();
    drive(1, mk(0,0,0,0,0,3,1,2), mk(0,0,0,0,0,4,1,4));
    step_chk("tp2_t0", E0_HOLD);
    step_chk("tp2_t1", 6'b11_00_01);
    idle();
    count_chk("tp2_count", 16'd2);

    // i1 depends on i0 (lat 2): waits in SECOND one extra cycle.
    do_reset();
    drive(1, mk(0,0,0,0,0,5,1,2), mk(1,5,0,0,3'b001,6,1,1));
    step_chk("raw2_t0", E0_HOLD);
    step_chk("raw2_t1", 6'b00_00_11);
    step_chk("raw2_t2", 6'b00_11_01);

    // Latency-7 producer blocks a reader of rb for six cycles.
    do_reset();
    drive(1, mk(0,0,0,0,0,10,1,7), mk(1,0,0,0,0,11,1,1));
    step_chk("raw7_prod", DUAL);
    drive(1, mk(0,0,10,0,3'b010,12,1,1), mk(1,0,0,0,0,13,1,1));
    for (int k = 0; k < 6; k++) step_chk("raw7_stall", STALLED);
    step_chk("raw7_go", DUAL);

    // WAW: cnt[8]=5 against lat 2 holds for four cycles.
    do_reset();
    drive(1, mk(0,0,0,0,0,8,1,6), mk(1,0,0,0,0,20,1,1));
    step_chk("waw_prod", DUAL);
    drive(1, mk(0,0,0,0,0,8,1,2), mk(1,0,0,0,0,21,1,1));
    for (int k = 0; k < 4; k++) step_chk("waw_stall", STALLED);
    step_chk("waw_go", DUAL);

    // Flush in SECOND: no issue, back to PAIR, scoreboard keeps counting (4 -> 3).
    do_reset();
    drive(1, mk(0,0,0,0,0,30,1,5), mk(0,0,0,0,0,31,1,1));
    step_chk("fl_first", E0_HOLD);
    flush = 1'b1;
    step_chk("fl_same", 6'b00_00_01);
    flush = 1'b0;
    drive(1, mk(0,30,0,0,3'b001,32,1,1), mk(1,0,0,0,0,33,1,1));
    for (int k = 0; k < 3; k++) step_chk("fl_cnt_stall", STALLED);
    step_chk("fl_go", DUAL);
    idle();
    count_chk("fl_count", 16'd3);

    // Reset mid-SECOND: outputs drop immediately, scoreboard and count cleared.
    do_reset();
    drive(1, mk(0,0,0,0,0,40,1,7), mk(0,0,0,0,0,41,1,1));
    step_chk("rs_first", E0_HOLD);
    reset = 1'b1;
    #2;
    chk("rs_outs", 32'(outs()), 32'd0);
    chk("rs_count", 32'(bus.issue_count), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    drive(1, mk(0,40,0,0,3'b001,42,1,1), mk(1,0,0,0,0,43,1,1));
    step_chk("rs_after", DUAL);
    idle();
    count_chk("rs_count_after", 16'd2);

    // Randomized run against the ready-time model.
    do_reset();
    for (int r = 0; r < 128; r++) ready[r] = 0;
    now    = 0;
    pend   = 1'b0;
    mcount = '0;
    hold   = 1'b0;
    rv     = 1'b0;
    ra_    = rnd_instr();
    rb_    = rnd_instr();
    for (int c = 0; c < 2000; c++) begin
      bit ha, hb, ia, ib, st, npend;
      logic ie, io, ies, ios;
      if (!hold) begin
        rv  = ($urandom_range(3) != 0);
        ra_ = rnd_instr();
        rb_ = rnd_instr();
      end
      flush = ($urandom_range(15) == 0);
      drive(rv, ra_, rb_);

      ha = m_haz(ra_);
      hb = m_haz(rb_);
      ia = 0; ib = 0; st = 0; npend = pend;
      if (flush) begin
        npend = 0;
      end else if (pend) begin
        if (!hb) begin ib = 1; npend = 0; end
        else st = 1;
      end else if (rv) begin
        if (ha) st = 1;
        else begin
          ia = 1;
          if (ra_.pipe != rb_.pipe && !hb && !(ra_.wr && reads(rb_, ra_.rt)) &&
              !(ra_.wr && rb_.wr && ra_.rt == rb_.rt)) ib = 1;
          else begin st = 1; npend = 1; end
        end
      end
      ie = 0; io = 0; ies = 0; ios = 0;
      if (ia) begin if (ra_.pipe) io = 1; else ie = 1; end
      if (ib) begin if (rb_.pipe) begin io = 1; ios = 1; end else begin ie = 1; ies = 1; end end

      @(negedge clock);
      chk("rand_outs", 32'(outs()), 32'({ie, ies, io, ios, st, pend}));
      chk("rand_count", 32'(bus.issue_count), 32'(mcount));

      if (ia && ra_.wr) ready[ra_.rt] = now + leff(ra_.lat);
      if (ib && rb_.wr) ready[rb_.rt] = now + leff(rb_.lat);
      mcount = mcount + 16'(int'(ia) + int'(ib));
      now++;
      pend = npend;
      hold = st;
      @(posedge clock);
      #1;
    end
    flush = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
